riscv_test_checker: RTL and testbench
=====================================

Name: riscv_test_checker

Overview:
- Synthesizable, parametrised run-and-check sequencer for the RV32I core.
- On each start it holds the core in reset, releases it for a fixed cycle budget, then freezes it again.
- While frozen, it walks the register file and, optionally, data memory through read ports, comparing each word against an expected-value ROM.
- Reports error count, first failing index and pass/fail. It sits beside riscv_top and is driven by the bench or an FPGA wrapper.

Parameters:
NB_DATA, 32, data word width
NB_REG_ADDR, 5, register file address width
N_CHECK_REGS, 32, registers compared, indices 0..N_CHECK_REGS-1 (1..2**NB_REG_ADDR)
NB_MEM_ADDR, 8, data memory word-address width
MEM_WORDS, 64, memory words compared, addresses 0..MEM_WORDS-1 (1..2**NB_MEM_ADDR)
RESET_CYCLES, 2, cycles core reset is held after start (>=1)
RUN_CYCLES, 300, cycles core runs (>=1)
NB_ERR, 16, error counter width

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_start  in  1  start pulse; sampled only in IDLE or DONE
o_core_reset  out  1  reset to riscv_top
o_rf_addr  out  NB_REG_ADDR  register file read address
i_rf_data  in  NB_DATA  register data, valid 1 cycle after address
o_mem_addr  out  NB_MEM_ADDR  data memory word read address
i_mem_data  in  NB_DATA  memory data, valid 1 cycle after address
o_exp_addr  out  NB_MEM_ADDR+1  expected ROM address: registers at 0..N_CHECK_REGS-1, memory at N_CHECK_REGS+k
i_exp_data  in  NB_DATA  expected data, valid 1 cycle after address
o_busy  out  1  high in RESET_CORE, RUN, CHECK_RF, CHECK_MEM
o_done  out  1  one-cycle pulse on entry to DONE
o_pass  out  1  valid in DONE; high when error count is 0
o_err_count  out  NB_ERR  saturating mismatch count
o_first_err  out  NB_MEM_ADDR+1  expected-ROM index of first mismatch; all-ones if none

Behaviour:
- Reset values: state IDLE; o_core_reset=1; o_busy=0; o_done=0; o_pass=0; o_err_count=0; o_first_err=all-ones; all address outputs 0.
- Reset is asynchronous. Asserting it mid-operation aborts any state to IDLE with the reset values above.
- FSM states: IDLE, RESET_CORE, RUN, CHECK_RF, CHECK_MEM, DONE.
- IDLE/DONE, on i_start=1:
  - clear o_err_count, o_first_err and o_pass;
  - load the cycle counter;
  - go to RESET_CORE.
- DONE holds its results until i_start.
- RESET_CORE: o_core_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: o_core_reset=0 for exactly RUN_CYCLES cycles, then CHECK_RF.
- o_core_reset is 1 in every state except RUN, so architectural state stays frozen during checking.
- CHECK_RF is a 2-stage pipeline:
  - cycle t issues index i on o_rf_addr and o_exp_addr;
  - cycle t+1 compares i_rf_data against i_exp_data for index i.
  - Indices are issued back-to-back, 0..N_CHECK_REGS-1.
  - After the last issue, one drain cycle performs the final compare.
  - Total N_CHECK_REGS+1 cycles, then CHECK_MEM (or DONE, see Optional Feature).
- CHECK_MEM: same pipeline over k=0..MEM_WORDS-1 (o_mem_addr=k, o_exp_addr=N_CHECK_REGS+k). MEM_WORDS+1 cycles, then DONE.
- Mismatch handling:
  - o_err_count increments by 1 and saturates at 2**NB_ERR-1.
  - o_first_err latches only if it is still all-ones.
- x0 is compared like any other register.
- Entry to DONE: o_done high for exactly one cycle; o_pass = (o_err_count==0), including any mismatch from the final drain compare.
- i_start is ignored while o_busy=1.
- i_start held high in DONE begins a new run on the cycle after the o_done pulse.
- Counters are sized with $clog2 of the largest bound. No overflow occurs for any legal parameter set.

Optional Feature:
- Macro: RISCV_CHECK_MEM_EN.
- Defined: CHECK_MEM is present as described.
- Undefined:
  - CHECK_MEM is not built; CHECK_RF transitions directly to DONE.
  - o_mem_addr is tied to 0; i_mem_data is unused.
  - o_exp_addr never exceeds N_CHECK_REGS-1.

Test Plan:
- Reset then start, RESET_CYCLES=2, RUN_CYCLES=300 -> o_core_reset=1 for 2 cycles, 0 for exactly 300 cycles, then 1. o_busy high throughout. o_done pulses once at cycle 2+300+33 (N_CHECK_REGS=32, macro off).
- ROM equal to RF model -> o_pass=1, o_err_count=0, o_first_err=all-ones.
- RF model with x5 and x17 corrupted -> o_err_count=2, o_first_err=5, o_pass=0. Repeat with only x31 corrupted -> count 1, first_err 31 (drain compare checked).
- Macro on, MEM_WORDS=64, memory word 63 corrupted -> count 1, first_err=32+63=95. Macro off, same stimulus -> pass.
- NB_ERR=2, 5 register mismatches -> o_err_count saturates at 3.
- i_reset pulsed during RUN -> immediate IDLE, o_core_reset=1, o_busy=0, no o_done. i_start pulsed during CHECK_RF -> ignored, single o_done.

Source files
------------

// File: rtl/riscv_test_checker.sv
// Run-and-check sequencer for the RV32I core: resets the core, runs it for a fixed budget, then
// compares the register file (and data memory when RISCV_CHECK_MEM_EN is defined) against an expected ROM.
module riscv_test_checker #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG_ADDR  = 5,
    parameter int N_CHECK_REGS = 32,
    parameter int NB_MEM_ADDR  = 8,
    parameter int MEM_WORDS    = 64,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 300,
    parameter int NB_ERR       = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic                   o_core_reset,
    output logic [NB_REG_ADDR-1:0] o_rf_addr,
    input  logic [NB_DATA-1:0]     i_rf_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic [NB_MEM_ADDR:0]   o_exp_addr,
    input  logic [NB_DATA-1:0]     i_exp_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic [NB_ERR-1:0]      o_err_count,
    output logic [NB_MEM_ADDR:0]   o_first_err
);

    localparam int MAX_RR  = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
    localparam int MAX_CK  = (N_CHECK_REGS > MEM_WORDS) ? N_CHECK_REGS : MEM_WORDS;
    localparam int CNT_MAX = (MAX_RR > MAX_CK) ? MAX_RR : MAX_CK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int NB_EXP  = NB_MEM_ADDR + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_CORE, S_RUN, S_CHECK_RF, S_CHECK_MEM, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   core_reset_q, core_reset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [NB_ERR-1:0]      err_q, err_d;
    logic [NB_EXP-1:0]      first_err_q, first_err_d;
    logic [NB_REG_ADDR-1:0] rf_addr_q, rf_addr_d;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NB_EXP-1:0]      exp_addr_q, exp_addr_d;
    logic                   vld_p1_q, vld_p1_d;
    logic [NB_EXP-1:0]      idx_p1_q, idx_p1_d;
    logic [NB_DATA-1:0]     cmp_data;

    function automatic logic [NB_ERR-1:0] sat_inc(input logic [NB_ERR-1:0] v);
        return (&v) ? v : v + NB_ERR'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        rf_addr_d   = rf_addr_q;
        mem_addr_d  = mem_addr_q;
        exp_addr_d  = exp_addr_q;
        done_d      = 1'b0;
        vld_p1_d    = 1'b0;
        idx_p1_d    = exp_addr_q;

        // Stage p1: compare data returned for the index issued last cycle
        cmp_data = i_rf_data;
`ifdef RISCV_CHECK_MEM_EN
        if (state_q == S_CHECK_MEM) cmp_data = i_mem_data;
`endif
        if (vld_p1_q && (cmp_data != i_exp_data)) begin
            err_d = sat_inc(err_q);
            if (&first_err_q) first_err_d = idx_p1_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    err_d       = '0;
                    first_err_d = '1;
                    pass_d      = 1'b0;
                    cnt_d       = CNT_W'(RESET_CYCLES - 1);
                    state_d     = S_RESET_CORE;
                end
            end
            S_RESET_CORE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(RUN_CYCLES - 1);
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    cnt_d      = CNT_W'(N_CHECK_REGS);
                    rf_addr_d  = '0;
                    exp_addr_d = '0;
                    state_d    = S_CHECK_RF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // Stage p0: issue one index per cycle while cnt is nonzero; cnt==0 is the drain cycle
            S_CHECK_RF: begin
                if (cnt_q != '0) begin
                    vld_p1_d = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q != CNT_W'(1)) begin
                        rf_addr_d  = rf_addr_q + NB_REG_ADDR'(1);
                        exp_addr_d = exp_addr_q + NB_EXP'(1);
                    end
                end else begin
`ifdef RISCV_CHECK_MEM_EN
                    cnt_d      = CNT_W'(MEM_WORDS);
                    mem_addr_d = '0;
                    exp_addr_d = NB_EXP'(N_CHECK_REGS);
                    state_d    = S_CHECK_MEM;
`else
                    state_d    = S_DONE;
`endif
                end
            end
`ifdef RISCV_CHECK_MEM_EN
            S_CHECK_MEM: begin
                if (cnt_q != '0) begin
                    vld_p1_d = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q != CNT_W'(1)) begin
                        mem_addr_d = mem_addr_q + NB_MEM_ADDR'(1);
                        exp_addr_d = exp_addr_q + NB_EXP'(1);
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Pass is taken from err_d so a mismatch found in the final drain cycle counts
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == '0);
        end
        core_reset_d = (state_d != S_RUN);
        busy_d = (state_d == S_RESET_CORE) || (state_d == S_RUN) ||
                 (state_d == S_CHECK_RF) || (state_d == S_CHECK_MEM);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_err_q  <= '1;
            rf_addr_q    <= '0;
            mem_addr_q   <= '0;
            exp_addr_q   <= '0;
            vld_p1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_err_q  <= first_err_d;
            rf_addr_q    <= rf_addr_d;
            mem_addr_q   <= mem_addr_d;
            exp_addr_q   <= exp_addr_d;
            vld_p1_q     <= vld_p1_d;
        end
    end

    always_ff @(posedge i_clock) begin
        idx_p1_q <= idx_p1_d;
    end

    assign o_core_reset = core_reset_q;
    assign o_rf_addr    = rf_addr_q;
    assign o_exp_addr   = exp_addr_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_err_count  = err_q;
    assign o_first_err  = first_err_q;

`ifdef RISCV_CHECK_MEM_EN
    assign o_mem_addr = mem_addr_q;
`else
    logic unused_mem;
    logic [NB_MEM_ADDR-1:0] unused_mem_addr;
    assign unused_mem      = ^i_mem_data;
    assign unused_mem_addr = mem_addr_q ^ mem_addr_d;
    assign o_mem_addr      = '0;
`endif

endmodule

// File: tb/tb_riscv_test_checker.sv
// Directed/randomized bench for riscv_test_checker: synchronous RF/memory/ROM models and a
// mismatch model that counts differences between the ROM and the RF/memory contents.
module tb_riscv_test_checker;

    localparam int N    = 32;
    localparam int M    = 64;
    localparam int RC   = 2;
    localparam int RUN  = 300;
    localparam int S_RC = 1;
    localparam int S_RUN = 4;
`ifdef RISCV_CHECK_MEM_EN
    localparam int CHK_CYC = (N + 1) + (M + 1);
`else
    localparam int CHK_CYC = N + 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start_s;

    logic        core_reset, busy, done, pass;
    logic [4:0]  rf_addr;
    logic [7:0]  mem_addr;
    logic [8:0]  exp_addr, first_err;
    logic [15:0] err_count;
    logic [31:0] rf_rd, mem_rd, exp_rd;

    logic        core_reset_s, busy_s, done_s, pass_s;
    logic [4:0]  rf_addr_s;
    logic [7:0]  mem_addr_s;
    logic [8:0]  exp_addr_s, first_err_s;
    logic [1:0]  err_count_s;
    logic [31:0] rf_rd_s, mem_rd_s, exp_rd_s;

    logic [31:0] rf  [0:31];
    logic [31:0] mem [0:255];
    logic [31:0] rom [0:511];

    riscv_test_checker #(.N_CHECK_REGS(N), .MEM_WORDS(M), .RESET_CYCLES(RC),
                         .RUN_CYCLES(RUN), .NB_ERR(16)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .o_core_reset(core_reset),
        .o_rf_addr(rf_addr), .i_rf_data(rf_rd), .o_mem_addr(mem_addr), .i_mem_data(mem_rd),
        .o_exp_addr(exp_addr), .i_exp_data(exp_rd), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_err_count(err_count), .o_first_err(first_err));

    riscv_test_checker #(.N_CHECK_REGS(N), .MEM_WORDS(M), .RESET_CYCLES(S_RC),
                         .RUN_CYCLES(S_RUN), .NB_ERR(2)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_start(start_s), .o_core_reset(core_reset_s),
        .o_rf_addr(rf_addr_s), .i_rf_data(rf_rd_s), .o_mem_addr(mem_addr_s), .i_mem_data(mem_rd_s),
        .o_exp_addr(exp_addr_s), .i_exp_data(exp_rd_s), .o_busy(busy_s), .o_done(done_s),
        .o_pass(pass_s), .o_err_count(err_count_s), .o_first_err(first_err_s));

    always @(posedge clk) begin
        rf_rd    <= rf[rf_addr];
        mem_rd   <= mem[mem_addr];
        exp_rd   <= rom[exp_addr];
        rf_rd_s  <= rf[rf_addr_s];
        mem_rd_s <= mem[mem_addr_s];
        exp_rd_s <= rom[exp_addr_s];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a mismatch is any ROM word that differs from the word it describes
    function automatic void model(output int cnt, output int first);
        cnt = 0;
        first = 511;
        for (int i = 0; i < N; i++)
            if (rom[i] !== rf[i]) begin cnt++; if (first == 511) first = i; end
`ifdef RISCV_CHECK_MEM_EN
        for (int k = 0; k < M; k++)
            if (rom[N + k] !== mem[k]) begin cnt++; if (first == 511) first = N + k; end
`endif
    endfunction

    task automatic restore();
        for (int i = 0; i < 512; i++) rom[i] = 32'h0;
        for (int i = 0; i < N; i++) rom[i] = rf[i];
        for (int k = 0; k < M; k++) rom[N + k] = mem[k];
    endtask

    task automatic corrupt(input int idx);
        rom[idx] = rom[idx] ^ ($urandom() | 32'h1);
    endtask

    task automatic run_main(input string tag, input int start_k);
        int exp_done, done_k, ndone, first_low, nlow, busy_bad, ecnt, efirst;
        logic [15:0] got_err;
        logic [8:0]  got_first;
        logic        got_pass;
        exp_done = RC + RUN + CHK_CYC;
        model(ecnt, efirst);
        done_k = -1; ndone = 0; first_low = -1; nlow = 0; busy_bad = 0;
        got_err = '0; got_first = '0; got_pass = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k < exp_done + 20; k++) begin
            @(negedge clk);
            start = (k == start_k) ? 1'b1 : 1'b0;
            if (!core_reset) begin nlow++; if (first_low < 0) first_low = k; end
            if (done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k; got_err = err_count; got_first = first_err; got_pass = pass;
                end
            end
            if (done_k < 0 && !busy) busy_bad++;
            if (done_k >= 0 && k >= done_k + 6) break;
        end
        start = 1'b0;
        chk({tag, ".reset_cycles"}, first_low, RC);
        chk({tag, ".run_cycles"}, nlow, RUN);
        chk({tag, ".done_cycle"}, done_k, exp_done);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".busy_gap"}, busy_bad, 0);
        chk({tag, ".err_count"}, got_err, ecnt);
        chk({tag, ".first_err"}, got_first, efirst);
        chk({tag, ".pass"}, got_pass, (ecnt == 0));
        chk({tag, ".held_err"}, err_count, ecnt);
        chk({tag, ".idle_core_reset"}, core_reset, 1);
        chk({tag, ".idle_busy"}, busy, 0);
    endtask

    task automatic run_sat(input string tag);
        int ecnt, efirst, done_k;
        model(ecnt, efirst);
        done_k = -1;
        @(negedge clk) start_s = 1'b1;
        for (int k = 0; k < S_RC + S_RUN + CHK_CYC + 20; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done_s) begin done_k = k; break; end
        end
        chk({tag, ".done_cycle"}, done_k, S_RC + S_RUN + CHK_CYC);
        chk({tag, ".err_count"}, err_count_s, (ecnt > 3) ? 3 : ecnt);
        chk({tag, ".first_err"}, first_err_s, efirst);
        chk({tag, ".pass"}, pass_s, (ecnt == 0));
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = $urandom();
        for (int k = 0; k < 256; k++) mem[k] = $urandom();
        restore();
        repeat (3) @(negedge clk);
        chk("rst.core_reset", core_reset, 1);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.err_count", err_count, 0);
        chk("rst.first_err", first_err, 9'h1FF);
        chk("rst.addrs", {rf_addr, mem_addr, exp_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.busy", busy, 0);

        run_main("clean", -1);

        corrupt(5); corrupt(17);
        run_main("x5_x17", -1);

        restore(); corrupt(31);
        run_main("x31_drain", -1);

        restore(); corrupt(N + 63);
        run_main("mem63", -1);

        restore();
        for (int j = 0; j < 3; j++) corrupt($urandom_range(N - 1 + ((CHK_CYC > N + 1) ? M : 0), 0));
        run_main("random", -1);

        restore(); corrupt(0); corrupt(3); corrupt(9); corrupt(20); corrupt(31);
        run_sat("sat5");

        restore(); corrupt(12);
        run_main("start_in_check", RC + RUN + 10);

        // Asynchronous abort in the middle of RUN
        restore();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort.pre_core_reset", core_reset, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort.core_reset", core_reset, 1);
        chk("abort.busy", busy, 0);
        chk("abort.err_count", err_count, 0);
        chk("abort.first_err", first_err, 9'h1FF);
        @(negedge clk) rst = 1'b0;
        nd = 0;
        for (int k = 0; k < RUN + CHK_CYC + 20; k++) begin
            @(negedge clk);
            if (done || busy || !core_reset) nd++;
        end
        chk("abort.no_activity", nd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
